// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and constants for the FIFO write arbiter
// Purpose: state encoding, default data width shared with the FIFO, burst
// counter width helper.
package fifo_wr_arbiter_pkg;

    localparam int DW_DEFAULT        = 8;
    localparam int MAX_BURST_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter must hold 0..MAX_BURST.
    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int BURST_W_DEFAULT = $clog2(MAX_BURST_DEFAULT + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority picker
// Purpose: first set bit of req searching upward from last+1, wrapping.
// Ports: req (requests), last (previous winner), onehot/index (winner), any.
module fifo_wr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        idx    = '0;
        // k=N_REQ visits last itself, so it has lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!any && req[idx]) begin
                any         = 1'b1;
                onehot[idx] = 1'b1;
                index       = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter for the shared FIFO write port
// Purpose: grants one producer at a time for up to MAX_BURST words and
// forwards its data to the FIFO, never writing while fifo_full.
// Ports: clk/rst (sync active-high), req/din_bus from producers, gnt/ack to
// producers, fifo_full from FIFO, fifo_wr/fifo_din to FIFO.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = DW_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] din_bus,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BURST_W = burst_w(MAX_BURST);
    localparam logic [BURST_W-1:0] LAST_CNT = BURST_W'(MAX_BURST - 1);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic               busy;
    logic               final_word;
    logic               release_now;
    logic [DW-1:0]      din_sel;
    logic [N_REQ-1:0]   pick_req;
    logic [IDX_W-1:0]   pick_last;
    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    always_comb begin
        din_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) din_sel = din_bus[i*DW +: DW];
        end
    end

    assign busy        = (state_q == BUSY);
    assign fifo_wr     = busy & req[owner_q] & ~fifo_full;
    assign ack         = gnt_q & {N_REQ{fifo_wr}};
    assign fifo_din    = busy ? din_sel : '0;
    assign gnt         = gnt_q;
    assign final_word  = fifo_wr && (burst_cnt_q == LAST_CNT);
    assign release_now = busy && (!req[owner_q] || final_word);

    // An owner that just finished its burst is masked so others go first;
    // a lone requester therefore passes through IDLE for one cycle.
    assign pick_req  = final_word ? (req & ~gnt_q) : req;
    assign pick_last = busy ? owner_q : last_q;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req   (pick_req),
        .last  (pick_last),
        .onehot(pick_oh),
        .index (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = BUSY;
                    gnt_d       = pick_oh;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    last_d      = owner_q;
                    burst_cnt_d = '0;
                    if (pick_any) begin
                        gnt_d   = pick_oh;
                        owner_d = pick_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (fifo_wr) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
